pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, is the trap handler address (used only with TRAP_VECTOR_EN).
REQ-003 clk_pc  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_pc  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  pipeline hazard; the PC SHALL be held.
REQ-006 fetch_ready  input  1  fetch stage accepts the presented pc.
REQ-007 br_taken  input  1  conditional branch redirect request.
REQ-008 br_target  input  32  branch target.
REQ-009 jmp  input  1  unconditional jump redirect request.
REQ-010 jmp_target  input  32  jump target.
REQ-011 trap  input  1  trap request (TRAP_VECTOR_EN only).
REQ-012 trap_ret  input  1  return-from-trap request (TRAP_VECTOR_EN only).
REQ-013 pc  output  32  current fetch address (registered).
REQ-014 pc_valid  output  1  pc is a valid fetch request.
REQ-015 flush  output  1  one-cycle pulse; younger in-flight instructions are discarded.
REQ-016 epc  output  32  saved trap return address.

Function
REQ-017 States SHALL be BOOT, RUN, HOLD; the encoding is free.
REQ-018 BOOT: exactly one cycle after reset release; pc=RESET_PC, pc_valid=0; next state RUN.
REQ-019 RUN: pc_valid=1; accept = pc_valid & fetch_ready & ~stall.
REQ-020 On accept with no redirect, pc SHALL become pc+4 next cycle, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-021 RUN with stall=1 or fetch_ready=0 and no redirect: go to HOLD; pc SHALL NOT change.
REQ-022 HOLD: pc_valid=1, pc held; return to RUN the cycle after stall=0 and fetch_ready=1.
REQ-023 Redirect priority, highest first: trap, trap_ret, jmp, br_taken.
REQ-024 In RUN with stall=0, the winning redirect target SHALL load into pc next cycle, even if fetch_ready=0; flush=1 in that same cycle.
REQ-025 A redirect arriving while stall=1 (RUN or HOLD) SHALL be captured into a one-entry pending register; a later redirect SHALL overwrite it.
REQ-026 The cycle stall falls to 0 with a pending entry: pc SHALL load the pending target, pending clears, flush=1; a new redirect in that same cycle SHALL win over the pending entry.
REQ-027 Target bits [1:0] SHALL be forced to 2'b00 on load.
REQ-028 Redirect inputs in BOOT SHALL be ignored.
REQ-029 flush SHALL be 0 in every cycle except those named in REQ-024 and REQ-026.

Reset
REQ-030 On rst_pc=1, asynchronously: state=BOOT, pc=RESET_PC, pc_valid=0, flush=0, pending cleared, epc=0.
REQ-031 Reset asserted mid-HOLD or with a pending redirect SHALL discard all of it; no redirect is taken after release.

Configuration
REQ-032 Macro TRAP_VECTOR_EN defined: trap loads pc=TRAP_VEC and saves epc=current pc; trap_ret loads pc=epc. Both follow the REQ-024/REQ-025 timing.
REQ-033 Macro TRAP_VECTOR_EN absent: trap and trap_ret SHALL be ignored, epc tied to 0, and no epc storage is synthesised.

Verification
REQ-034 Reset release, fetch_ready=1 -> pc 0 (pc_valid=0) for one cycle, then 0, 4, 8, 12 on consecutive cycles.
REQ-035 pc=0x40, jmp=1 with jmp_target=0x203 and br_taken=1 in the same cycle -> next pc=0x200, flush=1 for exactly one cycle.
REQ-036 stall=1 for 3 cycles at pc=0x10, br_taken=1 (target 0x80) in stall cycle 1, jmp=1 (target 0x90) in stall cycle 2 -> pc held at 0x10 during the stall, then pc=0x90 the cycle after stall falls, single flush pulse.
REQ-037 pc=0xFFFF_FFFC accepted -> next pc=0x0000_0000.
REQ-038 TRAP_VECTOR_EN defined, trap at pc=0x24 -> pc=0x100 and epc=0x24; trap_ret later -> pc=0x24. Macro undefined, same stimulus -> pc continues to 0x28.
REQ-039 rst_pc pulsed during HOLD with a pending jmp to 0x300 -> pc=0 and pc_valid=0 in the cycle after release; 0x300 never appears on pc.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: fetch PC sequencer with BOOT/RUN/HOLD control, prioritised redirects and a one-entry pending redirect; optional trap support under `TRAP_VECTOR_EN`
module pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk_pc,
  input  logic        rst_pc,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        trap,
  input  logic        trap_ret,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic [31:0] epc
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  state_t      state;
  logic        red_v, red_trap, pend_v, pend_trap;
  logic [31:0] red_t, pend_t;
`ifdef TRAP_VECTOR_EN
  // pick the highest-priority redirect this cycle: trap, trap_ret, jmp, br_taken
  always_comb begin
    red_v    = trap | trap_ret | jmp | br_taken;
    red_trap = trap;
    red_t    = (trap ? TRAP_VEC : trap_ret ? epc : jmp ? jmp_target : br_target) & ~32'd3;
  end
  // remember the PC of the trapping instruction when the trap redirect is taken
  always_ff @(posedge clk_pc or posedge rst_pc) begin
    if (rst_pc) epc <= 32'd0;
    else if (state != BOOT && !stall && (red_v ? red_trap : (pend_v && pend_trap))) epc <= pc;
  end
`else
  logic unused;
  // without trap support only jmp and br_taken can redirect
  always_comb begin
    red_v    = jmp | br_taken;
    red_trap = 1'b0;
    red_t    = (jmp ? jmp_target : br_target) & ~32'd3;
  end
  assign epc    = 32'd0;
  assign unused = ^{trap, trap_ret, TRAP_VEC, pend_trap};
`endif
  // state, pc, pending redirect and flush; a stalled redirect is parked until stall drops
  always_ff @(posedge clk_pc or posedge rst_pc) begin
    if (rst_pc) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      pc_valid  <= 1'b0;
      flush     <= 1'b0;
      pend_v    <= 1'b0;
      pend_trap <= 1'b0;
      pend_t    <= 32'd0;
    end else begin
      flush <= 1'b0;
      if (state == BOOT) begin
        state    <= RUN;
        pc_valid <= 1'b1;
      end else if (stall) begin
        state <= HOLD;
        if (red_v) begin
          pend_v    <= 1'b1;
          pend_t    <= red_t;
          pend_trap <= red_trap;
        end
      end else if (red_v || pend_v) begin
        pc     <= red_v ? red_t : pend_t;
        flush  <= 1'b1;
        pend_v <= 1'b0;
        state  <= RUN;
      end else if (fetch_ready) begin
        pc    <= pc + 32'd4;
        state <= RUN;
      end else begin
        state <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: table-driven check of pc_seq redirects, stalls, wrap and reset, plus a reset-with-pending sequence
module tb_pc_seq;
  logic        clk_pc = 1'b0, rst_pc = 1'b1;
  logic        stall = 1'b0, fetch_ready = 1'b0, br_taken = 1'b0, jmp = 1'b0, trap = 1'b0, trap_ret = 1'b0;
  logic [31:0] br_target = 32'd0, jmp_target = 32'd0;
  logic [31:0] pc, epc;
  logic        pc_valid, flush;
  int          tests = 0, fails = 0;

  pc_seq dut (
    .clk_pc(clk_pc), .rst_pc(rst_pc), .stall(stall), .fetch_ready(fetch_ready),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .trap(trap), .trap_ret(trap_ret), .pc(pc), .pc_valid(pc_valid), .flush(flush), .epc(epc)
  );

  always #5 clk_pc = ~clk_pc;

  typedef struct packed {
    logic        st, fr, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        tr, tret;
    logic [31:0] pc;
    logic        val, fl;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic st, logic fr, logic br, logic [31:0] bt, logic jp, logic [31:0] jt,
                              logic tr, logic tret, logic [31:0] p, logic val, logic fl, logic [31:0] e);
    return '{st, fr, br, bt, jp, jt, tr, tret, p, val, fl, e};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [31:0] p, logic val, logic fl, logic [31:0] e);
    chk({tag, " pc"}, pc, p);
    chk({tag, " pc_valid"}, {31'd0, pc_valid}, {31'd0, val});
    chk({tag, " flush"}, {31'd0, flush}, {31'd0, fl});
    chk({tag, " epc"}, epc, e);
  endtask

  initial begin
`ifdef TRAP_VECTOR_EN
    logic [31:0] e = 32'h24;
`else
    logic [31:0] e = 32'h0;
`endif
    tbl[0]  = mk(0, 1, 0, 0,       1, 32'h500, 0, 0, 32'h0,   1, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0,       0, 0,       0, 0, 32'h4,   1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0,       0, 0,       0, 0, 32'h8,   1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0,       0, 0,       0, 0, 32'hC,   1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0,       1, 32'h40,  0, 0, 32'h40,  1, 1, 0);
    tbl[5]  = mk(0, 1, 1, 32'h80,  1, 32'h203, 0, 0, 32'h200, 1, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0,       0, 0,       0, 0, 32'h204, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,       0, 0,       0, 0, 32'h204, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 32'h11,  0, 0,       0, 0, 32'h10,  1, 1, 0);
    tbl[9]  = mk(1, 1, 1, 32'h80,  0, 0,       0, 0, 32'h10,  1, 0, 0);
    tbl[10] = mk(1, 1, 0, 0,       1, 32'h90,  0, 0, 32'h10,  1, 0, 0);
    tbl[11] = mk(1, 1, 0, 0,       0, 0,       0, 0, 32'h10,  1, 0, 0);
    tbl[12] = mk(0, 1, 0, 0,       0, 0,       0, 0, 32'h90,  1, 1, 0);
    tbl[13] = mk(0, 1, 0, 0,       0, 0,       0, 0, 32'h94,  1, 0, 0);
    tbl[14] = mk(1, 1, 1, 32'h20,  0, 0,       0, 0, 32'h94,  1, 0, 0);
    tbl[15] = mk(0, 1, 0, 0,       1, 32'h24,  0, 0, 32'h24,  1, 1, 0);
`ifdef TRAP_VECTOR_EN
    tbl[16] = mk(0, 1, 0, 0,       0, 0,       1, 0, 32'h100, 1, 1, e);
    tbl[17] = mk(0, 1, 0, 0,       0, 0,       0, 1, 32'h24,  1, 1, e);
`else
    tbl[16] = mk(0, 1, 0, 0,       0, 0,       1, 0, 32'h28,  1, 0, e);
    tbl[17] = mk(0, 1, 0, 0,       0, 0,       0, 1, 32'h2C,  1, 0, e);
`endif
    tbl[18] = mk(0, 1, 0, 0,       1, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFC, 1, 1, e);
    tbl[19] = mk(0, 1, 0, 0,       0, 0,       0, 0, 32'h0,   1, 0, e);
    tbl[20] = mk(0, 1, 0, 0,       0, 0,       0, 0, 32'h4,   1, 0, e);

    repeat (2) @(posedge clk_pc);
    #1 chk_out("reset", 32'h0, 0, 0, 0);
    rst_pc = 1'b0;
    #1 chk_out("boot", 32'h0, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      stall = tbl[i].st; fetch_ready = tbl[i].fr; br_taken = tbl[i].br; br_target = tbl[i].bt;
      jmp = tbl[i].jp; jmp_target = tbl[i].jt; trap = tbl[i].tr; trap_ret = tbl[i].tret;
      @(posedge clk_pc);
      #1 chk_out($sformatf("row%0d", i), tbl[i].pc, tbl[i].val, tbl[i].fl, tbl[i].epc);
    end

    // reset while holding with a pending jmp: the jmp must be discarded
    stall = 1'b1; fetch_ready = 1'b1; br_taken = 1'b0; trap = 1'b0; trap_ret = 1'b0; jmp = 1'b0;
    @(posedge clk_pc);
    #1 jmp = 1'b1; jmp_target = 32'h300;
    @(posedge clk_pc);
    #1 chk_out("hold_pend", 32'h4, 1, 0, e);
    jmp = 1'b0; rst_pc = 1'b1;
    #1 chk_out("async_rst", 32'h0, 0, 0, 0);
    @(posedge clk_pc);
    #1 rst_pc = 1'b0; stall = 1'b0;
    #1 chk_out("rel_boot", 32'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_pc);
      #1 chk_out($sformatf("rel%0d", i), 32'(4 * i), 1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
